cv32e40p_ft_breakage_monitor: RTL and testbench
===============================================

Name: cv32e40p_ft_breakage_monitor

Overview:
- Consumer of per-replica voter mismatch flags from any triplicated (FT) sub-block of the IF stage, e.g. prefetch buffer, aligner or compressed decoder.
- Keeps one leaky-bucket counter per replica and declares a replica permanently broken when its counter reaches the breaking threshold.
- Reports each newly broken replica to the fault manager over a valid/ready handshake.
- The INCREMENT/DECREMENT/BREAKING_THRESHOLD/COUNT_BIT/INC_DEC_BIT values per sub-block (e.g. PRBU_*) are the intended parameter bindings.

Parameters:
- N_REPLICA, 3, number of redundant copies monitored.
- COUNT_BIT, 8, width of each counter.
- INC_DEC_BIT, 2, width of INCREMENT/DECREMENT.
- INCREMENT, 1, counter step on mismatch.
- DECREMENT, 1, counter step on agreement.
- BREAKING_THRESHOLD, 3, count at which a replica is declared broken.
- MODULE_ID, 0, sub-block identifier returned on reports (e.g. CVIFST_PRBUFT = 1).
- ID_BIT, 3, width of report_id_o.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- en_i  in  1  monitor enable; when 0, counters hold.
- err_valid_i  in  1  err_i is meaningful this cycle (the voter compared outputs).
- err_i  in  N_REPLICA  bit r = replica r disagreed with the majority.
- clear_i  in  1  synchronous soft clear of all monitor state (fault manager repaired or reconfigured).
- count_o  out  N_REPLICA*COUNT_BIT  concatenated counters, replica 0 in LSBs.
- broken_o  out  N_REPLICA  sticky broken flags.
- multi_fault_o  out  1  two or more replicas broken; majority no longer trustworthy.
- report_valid_o  out  1  report available.
- report_ready_i  in  1  fault manager accepts the report.
- report_id_o  out  ID_BIT  equals MODULE_ID while report_valid_o is high.
- report_replica_o  out  $clog2(N_REPLICA)  index of the broken replica being reported.

Behaviour:
- Reset (rst=1 at an edge):
  - All counters, broken_o, pending bits and report_replica_o go to 0.
  - FSM goes to IDLE; report_valid_o=0, multi_fault_o=0.
  - Reset has priority over every other input.
- Counter update:
  - Occurs on an edge when en_i & err_valid_i & !clear_i, per replica r with broken_o[r]=0.
  - err_i[r]=1: count += INCREMENT, saturating at 2^COUNT_BIT-1.
  - err_i[r]=0: count -= DECREMENT, saturating at 0.
  - Arithmetic uses COUNT_BIT+1 bits internally; no wrap-around is allowed.
  - Counters of broken replicas are frozen.
- Break detection:
  - On the same edge, if the next count >= BREAKING_THRESHOLD, set broken_o[r] and pending[r].
  - Latency: err_i sampled at edge t gives count_o and broken_o updated after edge t.
- multi_fault_o: registered popcount(broken_o) >= 2, updated on the same edge as broken_o.
- Report FSM, states IDLE and REPORT:
  - IDLE: if pending != 0, latch report_replica_o = lowest set index of pending and go to REPORT. report_valid_o is therefore first high one cycle after broken_o.
  - REPORT: report_valid_o=1; report_replica_o and report_id_o are held stable until the handshake.
  - On report_valid_o & report_ready_i: clear that pending bit. If other pending bits remain, load the next lowest index and stay in REPORT (back-to-back reports). Otherwise go to IDLE.
  - In IDLE, report_valid_o=0.
- Simultaneous events:
  - Several replicas breaking on the same edge are reported one per handshake, in ascending index.
  - A replica breaking during a handshake edge is queued in pending and is not lost.
- clear_i:
  - At an edge, zeroes counters, broken_o, pending and multi_fault_o, and forces IDLE.
  - report_valid_o drops without a handshake; this is the only legal withdrawal of valid.
  - err_i is ignored on that edge.
- en_i=0: counters and broken state hold; the report FSM still runs.
- Invalid configuration: BREAKING_THRESHOLD > 2^COUNT_BIT-1 means the replica never breaks; flag with an elaboration-time assertion.

Test Plan:
- Defaults; err_i=3'b010 with err_valid_i=1 for 3 cycles -> count1 1,2,3; broken_o=3'b010 after 3rd edge; report_valid_o=1 the next cycle with report_replica_o=1, report_id_o=MODULE_ID; ready pulse -> valid=0 next cycle.
- Alternate err_i[0]=1/0 for 20 cycles starting from 0 -> count0 toggles 1,0; never broken; extra err_i=0 at count 0 stays 0 (no underflow).
- err_i=3'b101 for 3 cycles -> broken_o=3'b101, multi_fault_o=1; with ready held high, reports come out replica 0 then 2 on consecutive cycles, then valid=0.
- Replica 1 breaks with report_ready_i=0 for 10 cycles -> valid, replica and id stable all 10 cycles; a replica 2 break meanwhile is reported after replica 1 is accepted.
- COUNT_BIT=2, INCREMENT=3, threshold 3 -> count saturates at 3 and breaks on the 1st error. clear_i asserted while in REPORT -> next cycle all counts 0, broken_o=0, valid=0.
- rst during accumulation (count=2) -> all outputs 0 the next cycle; subsequent errors count from 0.

Source files
------------

// File: rtl/cv32e40p_ft_breakage_monitor.sv
// cv32e40p_ft_breakage_monitor
//   Watches the per-replica mismatch flags coming out of a triplicated IF-stage
//   voter. It keeps one leaky-bucket counter per replica. When a counter reaches
//   BREAKING_THRESHOLD, that replica is marked permanently broken. Each newly
//   broken replica is then reported to the fault manager over a valid/ready
//   handshake, lowest index first.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   en_i              monitor enable (counters hold when low, reporting still runs)
//   err_valid_i       err_i carries a voter comparison this cycle
//   err_i             bit r set: replica r disagreed with the majority
//   clear_i           synchronous soft clear of all monitor state
//   count_o           concatenated counters, replica 0 in the LSBs
//   broken_o          sticky broken flags
//   multi_fault_o     two or more replicas broken
//   report_valid_o    a broken-replica report is offered
//   report_ready_i    fault manager accepts the report
//   report_id_o       MODULE_ID of this sub-block
//   report_replica_o  index of the replica being reported

// Per-replica saturating leaky-bucket counter.
// hit_o flags that this update takes the count to or above the threshold.
module cv32e40p_ft_breakage_ctr #(
    parameter int unsigned COUNT_BIT          = 8,
    parameter int unsigned INCREMENT          = 1,
    parameter int unsigned DECREMENT          = 1,
    parameter int unsigned BREAKING_THRESHOLD = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 upd_i,
    input  logic                 err_i,
    output logic [COUNT_BIT-1:0] count_o,
    output logic                 hit_o
);
    localparam int unsigned        MAX_CNT     = 2**COUNT_BIT - 1;
    localparam logic [COUNT_BIT:0] MAX_W       = (COUNT_BIT+1)'(MAX_CNT);
    localparam logic [COUNT_BIT:0] INC_W       = (COUNT_BIT+1)'(INCREMENT);
    localparam logic [COUNT_BIT:0] DEC_W       = (COUNT_BIT+1)'(DECREMENT);
    localparam logic [COUNT_BIT:0] THR_W       = (COUNT_BIT+1)'(BREAKING_THRESHOLD);
    // A threshold above the counter range can never be reached.
    localparam bit                 NEVER_BREAK = (BREAKING_THRESHOLD > MAX_CNT);

    logic [COUNT_BIT-1:0] count_q;
    logic [COUNT_BIT:0]   cur, sum, nxt;

    // The extra MSB catches overflow before clamping, so the count never wraps.
    always_comb begin
        cur = {1'b0, count_q};
        sum = cur + INC_W;
        if (err_i) nxt = (sum > MAX_W) ? MAX_W : sum;
        else       nxt = (cur > DEC_W) ? (cur - DEC_W) : '0;
        hit_o = upd_i && !NEVER_BREAK && (nxt >= THR_W);
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) count_q <= '0;
        else if (upd_i)   count_q <= nxt[COUNT_BIT-1:0];
    end

    assign count_o = count_q;
endmodule

module cv32e40p_ft_breakage_monitor #(
    parameter int unsigned N_REPLICA          = 3,
    parameter int unsigned COUNT_BIT          = 8,
    parameter int unsigned INC_DEC_BIT        = 2,
    parameter int unsigned INCREMENT          = 1,
    parameter int unsigned DECREMENT          = 1,
    parameter int unsigned BREAKING_THRESHOLD = 3,
    parameter int unsigned MODULE_ID          = 0,
    parameter int unsigned ID_BIT             = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en_i,
    input  logic                           err_valid_i,
    input  logic [N_REPLICA-1:0]           err_i,
    input  logic                           clear_i,
    output logic [N_REPLICA*COUNT_BIT-1:0] count_o,
    output logic [N_REPLICA-1:0]           broken_o,
    output logic                           multi_fault_o,
    output logic                           report_valid_o,
    input  logic                           report_ready_i,
    output logic [ID_BIT-1:0]              report_id_o,
    output logic [$clog2(N_REPLICA)-1:0]   report_replica_o
);
    localparam int unsigned RW = $clog2(N_REPLICA);

    if (BREAKING_THRESHOLD > 2**COUNT_BIT - 1) begin : g_bad_threshold
        $error("BREAKING_THRESHOLD exceeds counter range: replicas can never break");
    end
    if (INCREMENT >= 2**INC_DEC_BIT || DECREMENT >= 2**INC_DEC_BIT) begin : g_bad_step
        $error("INCREMENT/DECREMENT do not fit in INC_DEC_BIT");
    end

    typedef enum logic {IDLE = 1'b0, REPORT = 1'b1} state_e;

    state_e                                state_q, state_d;
    logic [RW-1:0]                         rep_q, rep_d;
    logic [N_REPLICA-1:0]                  broken_q, broken_d;
    logic [N_REPLICA-1:0]                  pending_q, pending_d, pend_rem;
    logic [N_REPLICA-1:0]                  hit;
    logic                                  mf_q, mf_d;
    logic                                  upd_en;
    logic [N_REPLICA-1:0][COUNT_BIT-1:0]   cnt;

    assign upd_en = en_i & err_valid_i & ~clear_i;

    for (genvar r = 0; r < N_REPLICA; r++) begin : g_rep
        cv32e40p_ft_breakage_ctr #(
            .COUNT_BIT          (COUNT_BIT),
            .INCREMENT          (INCREMENT),
            .DECREMENT          (DECREMENT),
            .BREAKING_THRESHOLD (BREAKING_THRESHOLD)
        ) u_ctr (
            .clk     (clk),
            .rst     (rst),
            .clr_i   (clear_i),
            .upd_i   (upd_en & ~broken_q[r]),   // broken replicas are frozen
            .err_i   (err_i[r]),
            .count_o (cnt[r]),
            .hit_o   (hit[r])
        );
    end

    function automatic logic [RW-1:0] lowest(input logic [N_REPLICA-1:0] v);
        lowest = '0;
        for (int i = N_REPLICA - 1; i >= 0; i--)
            if (v[i]) lowest = RW'(i);
    endfunction

    // The report FSM only consumes pending bits already registered.
    // A break on the same edge is OR-ed in afterwards, so it is queued and never lost.
    always_comb begin
        state_d  = state_q;
        rep_d    = rep_q;
        pend_rem = pending_q;
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    rep_d   = lowest(pending_q);
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (report_ready_i) begin
                    pend_rem = pending_q & ~(N_REPLICA'(1) << rep_q);
                    if (|pend_rem) rep_d = lowest(pend_rem);
                    else           state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        pending_d = pend_rem | hit;
        broken_d  = broken_q | hit;
    end

    always_comb begin
        int unsigned nb;
        nb = 0;
        for (int i = 0; i < N_REPLICA; i++)
            if (broken_d[i]) nb++;
        mf_d = (nb >= 2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rep_q     <= '0;
            broken_q  <= '0;
            pending_q <= '0;
            mf_q      <= 1'b0;
        end else if (clear_i) begin
            state_q   <= IDLE;
            broken_q  <= '0;
            pending_q <= '0;
            mf_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            rep_q     <= rep_d;
            broken_q  <= broken_d;
            pending_q <= pending_d;
            mf_q      <= mf_d;
        end
    end

    assign count_o          = cnt;
    assign broken_o         = broken_q;
    assign multi_fault_o    = mf_q;
    assign report_valid_o   = (state_q == REPORT);
    assign report_id_o      = ID_BIT'(MODULE_ID);
    assign report_replica_o = rep_q;
endmodule

// File: tb/tb_cv32e40p_ft_breakage_monitor.sv
module tb_cv32e40p_ft_breakage_monitor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: default configuration, MODULE_ID=5
    logic        rst, en, ev, clr, rdy;
    logic [2:0]  err;
    logic [23:0] count;
    logic [2:0]  broken;
    logic        mf, valid;
    logic [2:0]  id;
    logic [1:0]  rep;

    // Second DUT: COUNT_BIT=2, INCREMENT=3, threshold 3, MODULE_ID=2
    logic        en2, ev2, clr2, rdy2;
    logic [2:0]  err2;
    logic [5:0]  count2;
    logic [2:0]  broken2;
    logic        mf2, valid2;
    logic [2:0]  id2;
    logic [1:0]  rep2;

    cv32e40p_ft_breakage_monitor #(.MODULE_ID(5)) dut (
        .clk(clk), .rst(rst), .en_i(en), .err_valid_i(ev), .err_i(err), .clear_i(clr),
        .count_o(count), .broken_o(broken), .multi_fault_o(mf), .report_valid_o(valid),
        .report_ready_i(rdy), .report_id_o(id), .report_replica_o(rep));

    cv32e40p_ft_breakage_monitor #(.COUNT_BIT(2), .INC_DEC_BIT(2), .INCREMENT(3), .DECREMENT(1),
                                   .BREAKING_THRESHOLD(3), .MODULE_ID(2)) dut2 (
        .clk(clk), .rst(rst), .en_i(en2), .err_valid_i(ev2), .err_i(err2), .clear_i(clr2),
        .count_o(count2), .broken_o(broken2), .multi_fault_o(mf2), .report_valid_o(valid2),
        .report_ready_i(rdy2), .report_id_o(id2), .report_replica_o(rep2));

    int checks = 0;
    int failures = 0;

    // Reference model of the main DUT, kept at the level of the behavioural rules
    localparam int M_MAX = 255, M_INC = 1, M_DEC = 1, M_THR = 3;
    int       m_cnt [3];
    bit [2:0] m_brk, m_pend;
    bit       m_mf, m_valid;
    int       m_rep;

    function automatic int lowest(bit [2:0] v);
        lowest = 0;
        for (int i = 2; i >= 0; i--) if (v[i]) lowest = i;
    endfunction

    task automatic model_step();
        bit [2:0] np;
        if (rst) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_brk = 0; m_pend = 0; m_mf = 0; m_valid = 0; m_rep = 0;
        end else if (clr) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_brk = 0; m_pend = 0; m_mf = 0; m_valid = 0;
        end else begin
            np = m_pend;
            if (!m_valid) begin
                if (m_pend != 0) begin m_valid = 1; m_rep = lowest(m_pend); end
            end else if (rdy) begin
                np[m_rep] = 1'b0;
                if (np != 0) m_rep = lowest(np);
                else         m_valid = 0;
            end
            if (en && ev) begin
                for (int r = 0; r < 3; r++) begin
                    if (!m_brk[r]) begin
                        if (err[r]) m_cnt[r] = (m_cnt[r] + M_INC > M_MAX) ? M_MAX : m_cnt[r] + M_INC;
                        else        m_cnt[r] = (m_cnt[r] < M_DEC) ? 0 : m_cnt[r] - M_DEC;
                        if (m_cnt[r] >= M_THR) begin m_brk[r] = 1; np[r] = 1; end
                    end
                end
            end
            m_pend = np;
            m_mf = ($countones(m_brk) >= 2);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_clear();
        clr = 1; clr2 = 1; tick(); clr = 0; clr2 = 0;
    endtask

    task automatic test_reset();
        rst = 1; tick(); rst = 0;
        checks++; if (count !== 24'h0)   begin failures++; $display("FAIL reset_count got=%h exp=0", count); end
        checks++; if (broken !== 3'b000) begin failures++; $display("FAIL reset_broken got=%b exp=000", broken); end
        checks++; if (mf !== 1'b0)       begin failures++; $display("FAIL reset_mf got=%b exp=0", mf); end
        checks++; if (valid !== 1'b0)    begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (rep !== 2'd0)      begin failures++; $display("FAIL reset_rep got=%0d exp=0", rep); end
        checks++; if (count2 !== 6'h0 || broken2 !== 3'b0 || valid2 !== 1'b0)
            begin failures++; $display("FAIL reset_dut2 got cnt=%h brk=%b vld=%b exp 0", count2, broken2, valid2); end
    endtask

    task automatic test_basic_break();
        logic [23:0] e;
        en = 1; ev = 1; err = 3'b010; rdy = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            e = 24'(i) << 8;
            checks++; if (count !== e) begin failures++; $display("FAIL basic_cnt step=%0d got=%h exp=%h", i, count, e); end
        end
        checks++; if (broken !== 3'b010) begin failures++; $display("FAIL basic_broken got=%b exp=010", broken); end
        checks++; if (valid !== 1'b0)    begin failures++; $display("FAIL basic_valid_early got=%b exp=0", valid); end
        ev = 0; tick();
        checks++; if (valid !== 1'b1 || rep !== 2'd1 || id !== 3'd5)
            begin failures++; $display("FAIL basic_report got v=%b r=%0d id=%0d exp v=1 r=1 id=5", valid, rep, id); end
        rdy = 1; tick(); rdy = 0;
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL basic_after_hs got=%b exp=0", valid); end
        checks++; if (count !== 24'h000300 || mf !== 1'b0)
            begin failures++; $display("FAIL basic_frozen got cnt=%h mf=%b exp 000300 0", count, mf); end
        do_clear();
        checks++; if (count !== 24'h0 || broken !== 3'b0) begin failures++; $display("FAIL basic_clear got cnt=%h brk=%b", count, broken); end
    endtask

    task automatic test_alternate();
        logic [23:0] e;
        en = 1; ev = 1;
        for (int i = 0; i < 20; i++) begin
            err = (i % 2 == 0) ? 3'b001 : 3'b000;
            tick();
            e = (i % 2 == 0) ? 24'h1 : 24'h0;
            checks++; if (count !== e || broken !== 3'b0)
                begin failures++; $display("FAIL alt_cnt i=%0d got cnt=%h brk=%b exp %h 000", i, count, broken, e); end
        end
        err = 3'b000; tick();
        checks++; if (count !== 24'h0) begin failures++; $display("FAIL alt_underflow got=%h exp=0", count); end
        ev = 0;
    endtask

    task automatic test_multi();
        do_clear();
        en = 1; ev = 1; err = 3'b101; rdy = 1;
        repeat (3) tick();
        ev = 0;
        checks++; if (broken !== 3'b101 || mf !== 1'b1 || valid !== 1'b0)
            begin failures++; $display("FAIL multi_break got brk=%b mf=%b v=%b exp 101 1 0", broken, mf, valid); end
        checks++; if (count !== {8'd3, 8'd0, 8'd3}) begin failures++; $display("FAIL multi_cnt got=%h exp=030003", count); end
        tick();
        checks++; if (valid !== 1'b1 || rep !== 2'd0) begin failures++; $display("FAIL multi_first got v=%b r=%0d exp 1 0", valid, rep); end
        tick();
        checks++; if (valid !== 1'b1 || rep !== 2'd2) begin failures++; $display("FAIL multi_second got v=%b r=%0d exp 1 2", valid, rep); end
        tick();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL multi_done got v=%b exp 0", valid); end
        rdy = 0;
    endtask

    task automatic test_stall();
        do_clear();
        en = 1; ev = 1; err = 3'b010; rdy = 0;
        repeat (3) tick();
        ev = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (valid !== 1'b1 || rep !== 2'd1 || id !== 3'd5)
                begin failures++; $display("FAIL stall_hold i=%0d got v=%b r=%0d id=%0d exp 1 1 5", i, valid, rep, id); end
            if (i == 3) begin ev = 1; err = 3'b100; end
            if (i == 6) ev = 0;
        end
        checks++; if (broken !== 3'b110 || mf !== 1'b1) begin failures++; $display("FAIL stall_broken got %b mf=%b exp 110 1", broken, mf); end
        rdy = 1; tick();
        checks++; if (valid !== 1'b1 || rep !== 2'd2) begin failures++; $display("FAIL stall_next got v=%b r=%0d exp 1 2", valid, rep); end
        tick(); rdy = 0;
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL stall_done got v=%b exp 0", valid); end
    endtask

    task automatic test_rst_mid();
        do_clear();
        en = 1; ev = 1; err = 3'b001;
        repeat (2) tick();
        checks++; if (count !== 24'h2) begin failures++; $display("FAIL rstmid_acc got=%h exp=2", count); end
        rst = 1; tick(); rst = 0;
        checks++; if (count !== 24'h0 || broken !== 3'b0 || valid !== 1'b0 || mf !== 1'b0)
            begin failures++; $display("FAIL rstmid_zero got cnt=%h brk=%b v=%b mf=%b", count, broken, valid, mf); end
        tick();
        checks++; if (count !== 24'h1) begin failures++; $display("FAIL rstmid_restart got=%h exp=1", count); end
        en = 0; err = 3'b111; tick();
        checks++; if (count !== 24'h1 || broken !== 3'b0) begin failures++; $display("FAIL en_hold got cnt=%h brk=%b exp 1 000", count, broken); end
        en = 1; ev = 0; err = 0;
    endtask

    task automatic test_sat_clear();
        en2 = 1; ev2 = 1; err2 = 3'b001; rdy2 = 0;
        tick();
        checks++; if (count2 !== 6'b000011 || broken2 !== 3'b001)
            begin failures++; $display("FAIL sat_first got cnt=%b brk=%b exp 000011 001", count2, broken2); end
        ev2 = 0; tick();
        checks++; if (valid2 !== 1'b1 || rep2 !== 2'd0 || id2 !== 3'd2)
            begin failures++; $display("FAIL sat_report got v=%b r=%0d id=%0d exp 1 0 2", valid2, rep2, id2); end
        clr2 = 1; tick(); clr2 = 0;
        checks++; if (count2 !== 6'h0 || broken2 !== 3'b0 || valid2 !== 1'b0 || mf2 !== 1'b0)
            begin failures++; $display("FAIL sat_clear got cnt=%b brk=%b v=%b mf=%b exp 0", count2, broken2, valid2, mf2); end
    endtask

    task automatic test_random();
        logic [23:0] e;
        rst = 1; tick(); rst = 0;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom % 150 == 0);
            clr = ($urandom % 80 == 0);
            en  = ($urandom % 8 != 0);
            ev  = ($urandom % 4 != 0);
            for (int b = 0; b < 3; b++) err[b] = ($urandom % 3 == 0);
            rdy = $urandom % 2;
            tick();
            e = {8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])};
            checks++; if (count !== e)      begin failures++; $display("FAIL rnd_count c=%0d got=%h exp=%h", c, count, e); end
            checks++; if (broken !== m_brk) begin failures++; $display("FAIL rnd_broken c=%0d got=%b exp=%b", c, broken, m_brk); end
            checks++; if (mf !== m_mf)      begin failures++; $display("FAIL rnd_mf c=%0d got=%b exp=%b", c, mf, m_mf); end
            checks++; if (valid !== m_valid) begin failures++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, valid, m_valid); end
            if (m_valid) begin
                checks++; if (rep !== 2'(m_rep) || id !== 3'd5)
                    begin failures++; $display("FAIL rnd_report c=%0d got r=%0d id=%0d exp r=%0d id=5", c, rep, id, m_rep); end
            end
        end
        rst = 0; clr = 0; ev = 0; rdy = 0;
    endtask

    initial begin
        rst = 1; en = 0; ev = 0; err = 0; clr = 0; rdy = 0;
        en2 = 0; ev2 = 0; err2 = 0; clr2 = 0; rdy2 = 0;
        test_reset();
        test_basic_break();
        test_alternate();
        test_multi();
        test_stall();
        test_rst_mid();
        test_sat_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
